// File: rtl/conv_row_collector.sv
`default_nettype none
// ============================================================================
// Module      : conv_row_collector
// Description : Collects the y_out stream from the last PE of a systolic
//               convolution chain. Discards the TAPS-1 pipeline-fill samples
//               at the start of each row, scales each valid result with a
//               round-half-up right shift, narrows it to OUT_W and buffers it
//               in a FIFO with a valid/ready output. Pulses done once every
//               result of the row has been handed off.
// Build macro : COLLECT_SAT_EN - when defined, results above 2^OUT_W-1
//               saturate; otherwise they are truncated to OUT_W bits.
// Ports       : clk, rst_n (sync, active-low)
//               start, row_len          - row launch (accepted in IDLE only)
//               y_in, y_valid           - partial-sum stream from the chain
//               out_data, out_valid,
//               out_ready               - FIFO head, valid/ready handshake
//               busy, done, overflow    - status (overflow is sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module conv_row_collector #(
  parameter int DATA_W     = 16,
  parameter int OUT_W      = 8,
  parameter int TAPS       = 3,
  parameter int SHIFT      = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       row_len,
  input  logic [DATA_W-1:0] y_in,
  input  logic              y_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [15:0]        r_skip_cnt, w_skip_nxt;
  logic [15:0]        r_emit_cnt, w_emit_nxt;
  logic               w_capture;
  logic               w_done_nxt;

  logic               r_arith_valid;
  logic [OUT_W-1:0]   r_arith_data;
  logic [DATA_W:0]    w_r;
  logic [OUT_W-1:0]   w_narrow;

  logic [OUT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_AW:0]      r_count;
  logic               w_empty, w_full, w_pop, w_push;
  logic               r_done, r_overflow;

  // ---------------------------------------------------------------- arithmetic
  // The rounding add is done one bit wider than the input so that a full-scale
  // sample cannot wrap before the shift.
  generate
    if (SHIFT == 0) begin : g_pass
      assign w_r = {1'b0, y_in};
    end else begin : g_round
      localparam logic [DATA_W:0] c_RND = (DATA_W+1)'(1) << (SHIFT - 1);
      logic [DATA_W:0] w_sum;
      assign w_sum = {1'b0, y_in} + c_RND;
      assign w_r   = w_sum >> SHIFT;
    end
  endgenerate

`ifdef COLLECT_SAT_EN
  localparam int c_CW = (DATA_W + 1 > OUT_W) ? DATA_W + 1 : OUT_W;
  localparam logic [c_CW-1:0] c_MAX = c_CW'({OUT_W{1'b1}});
  logic [c_CW-1:0] w_r_ext;
  assign w_r_ext  = c_CW'(w_r);
  assign w_narrow = (w_r_ext > c_MAX) ? {OUT_W{1'b1}} : w_r_ext[OUT_W-1:0];
`else
  assign w_narrow = OUT_W'(w_r);
`endif

  // ---------------------------------------------------------------------- FIFO
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (c_AW+1)'(FIFO_DEPTH));
  assign w_pop     = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push    = r_arith_valid & (~w_full | w_pop);
  assign out_valid = ~w_empty;
  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_arith_data;
  end

  // ----------------------------------------------------------------------- FSM
  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip_cnt;
    w_emit_nxt  = r_emit_cnt;
    w_capture   = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (row_len >= 16'(TAPS)) begin
            w_skip_nxt  = 16'(TAPS - 1);
            w_emit_nxt  = row_len - 16'(TAPS - 1);
            w_state_nxt = (TAPS == 1) ? S_RUN : S_FILL;
          end else begin
            w_skip_nxt  = '0;
            w_emit_nxt  = '0;
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_FILL: begin
        if (r_skip_cnt == '0) begin
          w_state_nxt = S_RUN;
        end else if (y_valid) begin
          w_skip_nxt = r_skip_cnt - 16'd1;
          if (r_skip_cnt == 16'd1) w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (y_valid) begin
          w_capture  = 1'b1;
          w_emit_nxt = r_emit_cnt - 16'd1;
          if (r_emit_cnt == 16'd1) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (~r_arith_valid && w_empty) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_skip_cnt    <= '0;
      r_emit_cnt    <= '0;
      r_arith_valid <= 1'b0;
      r_arith_data  <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_skip_cnt    <= w_skip_nxt;
      r_emit_cnt    <= w_emit_nxt;
      r_arith_valid <= w_capture;
      if (w_capture) r_arith_data <= w_narrow;
      r_done        <= w_done_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // The emit counter already advanced on capture, so a dropped sample
      // never stalls row completion.
      if (r_arith_valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_conv_row_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_row_collector
// Description : Directed self-checking bench for conv_row_collector with
//               default parameters (DATA_W=16, OUT_W=8, TAPS=3, SHIFT=2,
//               FIFO_DEPTH=8). Expected values are hand-computed from
//               r = (y + 2) >> 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_row_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] row_len = '0;
  logic [15:0] y_in = '0;
  logic        y_valid = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        overflow;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cnt = 0;
  logic [7:0]  got_q[$];

  conv_row_collector dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .row_len  (row_len),
    .y_in     (y_in),
    .y_valid  (y_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Handshakes and done pulses are recorded mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(out_data);
    if (done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [15:0] v);
    y_in    = v;
    y_valid = 1'b1;
    step();
  endtask

  task automatic launch(input logic [15:0] len);
    start   = 1'b1;
    row_len = len;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    for (int i = 0; i < 200 && done_cnt == base; i++) step();
    check(tag, done_cnt - base, 1);
  endtask

  initial begin
    int b;
    int d;
    logic [7:0] exp_sat;

    // ---------------- reset state
    rst_n = 1'b0;
    step(); step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    step();

    // ---------------- fill discard: row_len 6 -> outputs 3,4,5,6
    out_ready = 1'b1;
    b = got_q.size();
    d = done_cnt;
    launch(16'd6);
    check("t1_busy", busy, 1);
    feed(16'd4); feed(16'd8); feed(16'd12); feed(16'd16); feed(16'd20); feed(16'd24);
    y_valid = 1'b0;
    wait_done(d, "t1_done");
    check("t1_count", got_q.size() - b, 4);
    for (int i = 0; i < 4; i++) check("t1_data", got_q[b + i], 3 + i);
    step(); step(); step();
    check("t1_single_done", done_cnt - d, 1);
    check("t1_busy_low", busy, 0);

    // ---------------- rounding / saturation: 1023 -> 256 -> wrap 0 or sat 255
`ifdef COLLECT_SAT_EN
    exp_sat = 8'd255;
`else
    exp_sat = 8'd0;
`endif
    b = got_q.size();
    d = done_cnt;
    launch(16'd4);
    feed(16'd0); feed(16'd0); feed(16'd1023); feed(16'd14);
    y_valid = 1'b0;
    wait_done(d, "t2_done");
    check("t2_count", got_q.size() - b, 2);
    check("t2_big", got_q[b], exp_sat);
    check("t2_small", got_q[b + 1], 4);

    // ---------------- short row: row_len 2 < TAPS
    d = done_cnt;
    b = got_q.size();
    launch(16'd2);
    check("t4_busy_drain", busy, 1);
    check("t4_no_done_yet", done, 0);
    step();
    check("t4_done", done, 1);
    check("t4_busy_low", busy, 0);
    check("t4_no_valid", out_valid, 0);
    step();
    check("t4_no_output", got_q.size() - b, 0);

    // ---------------- backpressure / overflow: 12 results into 8 entries
    out_ready = 1'b0;
    b = got_q.size();
    d = done_cnt;
    launch(16'd14);
    feed(16'd100); feed(16'd100);
    for (int k = 1; k <= 12; k++) feed(16'(4 * k));
    y_valid = 1'b0;
    step(); step(); step(); step(); step();
    check("t3_valid", out_valid, 1);
    check("t3_overflow", overflow, 1);
    check("t3_busy", busy, 1);
    check("t3_no_done", done_cnt - d, 0);
    check("t3_head", out_data, 1);
    step(); step();
    check("t3_head_stable", out_data, 1);
    out_ready = 1'b1;
    wait_done(d, "t3_done");
    check("t3_count", got_q.size() - b, 8);
    for (int i = 0; i < 8; i++) check("t3_data", got_q[b + i], 1 + i);

    // ---------------- start mid-RUN is ignored
    b = got_q.size();
    d = done_cnt;
    launch(16'd5);
    feed(16'd9); feed(16'd9); feed(16'd40);
    start   = 1'b1;
    row_len = 16'd3;
    feed(16'd44);
    start = 1'b0;
    feed(16'd48);
    y_valid = 1'b0;
    wait_done(d, "t5_done");
    check("t5_count", got_q.size() - b, 3);
    for (int i = 0; i < 3; i++) check("t5_data", got_q[b + i], 10 + i);
    step(); step(); step();
    check("t5_single_done", done_cnt - d, 1);
    check("t5_busy_low", busy, 0);

    // ---------------- latency and reset mid-RUN with 3 buffered results
    out_ready = 1'b0;
    d = done_cnt;
    launch(16'd10);
    feed(16'd0); feed(16'd0);
    feed(16'd40);
    check("t6_lat_empty", out_valid, 0);
    feed(16'd44);
    check("t6_lat_valid", out_valid, 1);
    feed(16'd48);
    y_valid = 1'b0;
    step();
    check("t6_head", out_data, 10);
    rst_n = 1'b0;
    step();
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_overflow", overflow, 0);
    check("t6_rst_done", done, 0);
    rst_n = 1'b1;
    step(); step(); step();
    check("t6_no_done", done_cnt - d, 0);
    check("t6_still_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
